// File: rtl/dram_fifo_pkg.sv
// ============================================================================
// Module  : dram_fifo_pkg
// Brief   : Shared geometry constants and level-update helper for dram_fifo64.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dram_fifo_pkg;

    localparam int DEPTH = 64;
    localparam int PTR_W = 6;
    localparam int LVL_W = 7;

    // Stored-word count after one handshake edge; push and pop together cancel.
    function automatic logic [LVL_W-1:0] level_next(
        input logic [LVL_W-1:0] lvl,
        input logic             push,
        input logic             pop
    );
        logic [LVL_W-1:0] nxt;
        nxt = lvl;
        case ({push, pop})
            2'b10:   nxt = lvl + LVL_W'(1);
            2'b01:   nxt = lvl - LVL_W'(1);
            default: nxt = lvl;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dram64xw.sv
// ============================================================================
// Module  : dram64xw
// Brief   : 64 x WIDTH distributed RAM, synchronous write, asynchronous read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dram64xw
    import dram_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Array is never reset; it powers up cleared.
    logic [WIDTH-1:0] r_mem [0:DEPTH-1] = '{default: '0};

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/dram_fifo64.sv
// ============================================================================
// Module  : dram_fifo64
// Brief   : 64-deep first-word-fall-through FIFO on distributed RAM with
//           registered level and almost-full / almost-empty flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_fifo64
    import dram_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int AFULL_LVL  = 56,
    parameter int AEMPTY_LVL = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [WIDTH-1:0] S_DATA,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [WIDTH-1:0] M_DATA,
    output logic [LVL_W-1:0] LEVEL,
    output logic             AFULL,
    output logic             AEMPTY
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_afull;
    logic             r_aempty;
    logic             r_live;

    logic             w_push;
    logic             w_pop;
    logic [LVL_W-1:0] w_level_nxt;

    // r_live holds S_READY low until the first edge after reset release.
    assign S_READY = r_live && (r_level != LVL_W'(DEPTH));
    assign M_VALID = (r_level != '0);
    assign LEVEL   = r_level;
    assign AFULL   = r_afull;
    assign AEMPTY  = r_aempty;

    assign w_push      = S_VALID && S_READY;
    assign w_pop       = M_VALID && M_READY;
    assign w_level_nxt = level_next(r_level, w_push, w_pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_live   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (FLUSH) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_afull  <= 1'b0;
                r_aempty <= 1'b1;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_level  <= w_level_nxt;
                // Flags track the level being loaded so they align with LEVEL.
                r_afull  <= (w_level_nxt >= LVL_W'(AFULL_LVL));
                r_aempty <= (w_level_nxt <= LVL_W'(AEMPTY_LVL));
            end
        end
    end

    dram64xw #(
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (CLK),
        .i_we    (w_push && !FLUSH),
        .i_waddr (r_wr_ptr),
        .i_wdata (S_DATA),
        .i_raddr (r_rd_ptr),
        .o_rdata (M_DATA)
    );

endmodule

`default_nettype wire

// File: tb/tb_dram_fifo64.sv
// ============================================================================
// Module  : tb_dram_fifo64
// Brief   : Scoreboard bench for dram_fifo64 with a queue-based reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_fifo64;

    localparam int WIDTH = 8;

    logic             CLK;
    logic             RST;
    logic             FLUSH;
    logic             S_VALID;
    logic             S_READY;
    logic [WIDTH-1:0] S_DATA;
    logic             M_VALID;
    logic             M_READY;
    logic [WIDTH-1:0] M_DATA;
    logic [6:0]       LEVEL;
    logic             AFULL;
    logic             AEMPTY;

    dram_fifo64 #(
        .WIDTH      (WIDTH),
        .AFULL_LVL  (56),
        .AEMPTY_LVL (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .FLUSH   (FLUSH),
        .S_VALID (S_VALID),
        .S_READY (S_READY),
        .S_DATA  (S_DATA),
        .M_VALID (M_VALID),
        .M_READY (M_READY),
        .M_DATA  (M_DATA),
        .LEVEL   (LEVEL),
        .AFULL   (AFULL),
        .AEMPTY  (AEMPTY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: ordered word queue plus a count and a liveness bit.
    logic [WIDTH-1:0] exp_q[$];
    int               mcnt  = 0;
    bit               alive = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT presents a head word, it must match the model.
    always @(negedge CLK) begin
        if (!RST && !FLUSH && M_VALID) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL m_data: DUT presents 0x%0h but model is empty at %0t",
                         M_DATA, $time);
            end else begin
                chk("m_data", int'(M_DATA), int'(exp_q[0]));
                if (M_READY) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; status is checked mid-cycle against the model.
    task automatic step(input bit sv, input logic [WIDTH-1:0] sd,
                        input bit mr, input bit fl);
        bit pu;
        bit po;
        S_VALID = sv;
        S_DATA  = sd;
        M_READY = mr;
        FLUSH   = fl;
        @(negedge CLK);
        chk("level",   int'(LEVEL),   mcnt);
        chk("s_ready", int'(S_READY), int'(alive && mcnt != 64));
        chk("m_valid", int'(M_VALID), int'(mcnt != 0));
        chk("afull",   int'(AFULL),   int'(mcnt >= 56));
        chk("aempty",  int'(AEMPTY),  int'(mcnt <= 8));
        pu = sv && alive && (mcnt != 64) && !fl;
        po = mr && (mcnt != 0) && !fl;
        if (pu) exp_q.push_back(sd);
        @(posedge CLK);
        if (fl) begin
            mcnt = 0;
            exp_q.delete();
        end else begin
            mcnt = mcnt + int'(pu) - int'(po);
        end
        alive = 1'b1;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 70 && mcnt != 0; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("drained", mcnt, 0);
    endtask

    initial begin
        RST     = 1'b1;
        FLUSH   = 1'b0;
        S_VALID = 1'b0;
        S_DATA  = '0;
        M_READY = 1'b0;
        #1;
        chk("rst_level",   int'(LEVEL),   0);
        chk("rst_s_ready", int'(S_READY), 0);
        chk("rst_m_valid", int'(M_VALID), 0);
        chk("rst_afull",   int'(AFULL),   0);
        chk("rst_aempty",  int'(AEMPTY),  1);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // First cycle after release: S_READY still low, offered word ignored.
        step(1'b1, 8'hEE, 1'b0, 1'b0);

        // Three pushes held, then popped in order.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("three_head", int'(M_DATA), 8'h11);
        drain();

        // Fill to 64 (threshold sweep on the way), overflow attempt, empty out.
        for (int i = 0; i < 64; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("full_level", int'(LEVEL), 64);
        drain();

        // Steady streaming at level 5 with pointer wrap.
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 5; i < 205; i++) step(1'b1, WIDTH'(8'h80 + i), 1'b1, 1'b0);
        chk("stream_level", int'(LEVEL), 5);
        drain();

        // Flush at level 40 with concurrent push and pop.
        for (int i = 0; i < 40; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b1);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        drain();

        // Asynchronous reset mid-burst at level 20.
        for (int i = 0; i < 20; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        S_VALID = 1'b1;
        M_READY = 1'b1;
        #2 RST = 1'b1;
        #1;
        chk("arst_level",   int'(LEVEL),   0);
        chk("arst_m_valid", int'(M_VALID), 0);
        chk("arst_s_ready", int'(S_READY), 0);
        chk("arst_afull",   int'(AFULL),   0);
        chk("arst_aempty",  int'(AEMPTY),  1);
        mcnt  = 0;
        alive = 1'b0;
        exp_q.delete();
        @(posedge CLK);
        #1 RST = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        drain();

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 60), WIDTH'($urandom),
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) == 0));
        end
        drain();
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
